// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack bus transaction, store lane replication, load extraction.
// Optional alignment exceptions are enabled by defining MEM_ALIGN_EXC_EN.
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic        u,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        bus_err,
  output logic        align_exc,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  // Bus handshake: bus_req is held high with constant addr/be/wdata/we until the
  // cycle in which bus_ack is sampled high; that cycle completes the transfer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        align_exc_q, align_exc_d;

  logic        be_byte, be_half, be_word, be_legal;
  logic        align_fault;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] wdata_rep;

  always_comb begin
    be_byte  = (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) || (be == 4'b1000);
    be_half  = (be == 4'b0011) || (be == 4'b1100);
    be_word  = (be == 4'b1111);
    be_legal = be_byte || be_half || be_word;
  end

`ifdef MEM_ALIGN_EXC_EN
  assign align_fault = (be_half && addr[0]) || (be_word && (addr[1:0] != 2'b00));
`else
  logic unused_addr;
  assign unused_addr = ^addr[1:0];
  assign align_fault = 1'b0;
`endif

  // Lane selection follows the byte enables, not the address, so the truncated
  // word address still extracts the lane the byte-enable generator chose.
  always_comb begin
    byte_sel = bus_rdata[7:0];
    case (be)
      4'b0010: byte_sel = bus_rdata[15:8];
      4'b0100: byte_sel = bus_rdata[23:16];
      4'b1000: byte_sel = bus_rdata[31:24];
      default: byte_sel = bus_rdata[7:0];
    endcase
    half_sel = (be == 4'b1100) ? bus_rdata[31:16] : bus_rdata[15:0];
    if (be_byte) begin
      load_val = u ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    end else if (be_half) begin
      load_val = u ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
    end else begin
      load_val = bus_rdata;
    end
  end

  always_comb begin
    if (be_byte) begin
      wdata_rep = {4{wdata[7:0]}};
    end else if (be_half) begin
      wdata_rep = {2{wdata[15:0]}};
    end else begin
      wdata_rep = wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    bus_err_d   = 1'b0;
    align_exc_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          if (!be_legal) begin
            state_d   = DONE;
            bus_err_d = 1'b1;
            rdata_d   = 32'h0;
          end else if (align_fault) begin
            state_d     = DONE;
            align_exc_d = 1'b1;
            rdata_d     = 32'h0;
          end else begin
            state_d     = BUS;
            cnt_d       = 8'h00;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_we;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = be;
            bus_wdata_d = wdata_rep;
          end
        end
      end
      BUS: begin
        if (bus_ack) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          rdata_d   = bus_we_q ? 32'h0 : load_val;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Abandoned transfer: a store is lost and a load returns zero.
          state_d   = DONE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          bus_err_d = 1'b1;
          rdata_d   = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'h00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      bus_err_q   <= 1'b0;
      align_exc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
      align_exc_q <= align_exc_d;
    end
  end

  // Reset gates stall so the pipeline is released the moment rst_n falls.
  assign stall     = rst_n & mem_req & (state_q != DONE);
  assign done      = (state_q == DONE);
  assign rdata     = rdata_q;
  assign bus_err   = bus_err_q;
  assign align_exc = align_exc_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access unit for the pipelined CPU's MEM stage, directly downstream of the byte-enable generator. It consumes the byte-enable mask and unsigned flag for the current load/store and runs a req/ack transaction on the data-memory bus. It lane-replicates store data and lane-extracts and extends load data. It stalls the pipeline until the access retires.

## Interface
Parameters:
- ACK_TIMEOUT, 255: maximum BUS-state cycles without `bus_ack` before abort; 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mem_req  in  1  MEM stage holds a load/store; held stable with all inputs until `done`
- mem_we  in  1  1 = store, 0 = load
- addr  in  32  byte address
- be  in  4  byte enables from the byte-enable generator
- u  in  1  unsigned-load flag from the byte-enable generator
- wdata  in  32  store data, right-aligned
- rdata  out  32  extended load result, valid when `done`
- done  out  1  one-cycle retire pulse
- stall  out  1  freeze upstream pipeline
- bus_err  out  1  one-cycle pulse with `done` on timeout or illegal `be`
- align_exc  out  1  one-cycle pulse with `done` on misalignment; only with macro
- bus_req, bus_we  out  1  bus request / write
- bus_addr  out  32  `{addr[31:2],2'b00}`
- bus_be  out  4  lane enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, sampled on `bus_ack`
- bus_ack  in  1  bus completion

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE to BUS: on `mem_req` with legal `be` and no alignment fault. Bus outputs are registered on this edge and held constant through BUS.
- IDLE to DONE: on `mem_req` with illegal `be` (`bus_err`) or an alignment fault (`align_exc`). No bus cycle is issued.
- BUS to DONE: on `bus_ack`, or when the timeout counter reaches ACK_TIMEOUT (`bus_err`, `rdata`=0, store lost).
- DONE to IDLE: unconditionally.
- Legal `be` values: 0001, 0010, 0100, 1000 (byte); 0011, 1100 (half); 1111 (word).
- Store replication:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- Load extraction:
  - byte: lane k = `bus_rdata[8k+7:8k]`
  - half: 0011 selects [15:0]; 1100 selects [31:16]
  - Sign-extend when `u`=0, zero-extend when `u`=1. Word loads ignore `u`.
- `rdata` is registered on the `bus_ack` cycle and held until the next access. It is 0 for stores and errors.
- Timeout counter: 8 bits, cleared on entering BUS, incremented each BUS cycle without ack.
- `stall` = `mem_req` & (state != DONE).

## Timing
- Reset values: state IDLE; all outputs 0, including `rdata` and bus outputs. Reset asserted mid-BUS drops `bus_req` immediately; the bus discards the abandoned cycle.
- Minimum latency: `mem_req` seen in cycle 0. `bus_req` is high in cycle 1; `bus_ack` may arrive in cycle 1. `done` and `rdata` are valid in cycle 2. `stall` is high in cycles 0–1.
- `bus_ack` outside BUS is ignored. Ack on the timeout cycle counts as success.
- `mem_req` high during DONE is not restarted; the next access begins in the following IDLE cycle.
- Error paths (illegal `be`, alignment fault) take 2 cycles: `done` in cycle 1.

## Configuration
- `MEM_ALIGN_EXC_EN` defined:
  - Faults: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - A faulting access has no bus cycle and no store; `align_exc` pulses with `done` for the interrupt controller.
- Undefined:
  - `align_exc` tied 0.
  - The access proceeds with the given `be` on the truncated word address.

## Test plan
- Load byte: `addr`=0x1003, `be`=1000, `u`=0, `bus_rdata`=0x80xxxxxx, ack in cycle 1 → `rdata`=0xFFFFFF80 with `done` in cycle 2; with `u`=1 → 0x00000080.
- Store half: `addr`=0x2002, `be`=1100, `wdata`=0x0000BEEF → `bus_addr`=0x2000, `bus_be`=1100, `bus_wdata`=0xBEEFBEEF, `bus_we`=1.
- Delayed ack 5 cycles: bus outputs stable throughout, `stall` high 6 cycles, single `done`.
- Timeout: ACK_TIMEOUT=4, no ack → `bus_err` and `done` together, `rdata`=0, FSM back in IDLE.
- Word load at `addr`=0x3001: with macro → `align_exc`=1 at cycle 1, `bus_req` never high; without macro → normal access at 0x3000.
- `rst_n` low during BUS → `bus_req`, `stall`, `done` all 0 immediately; after release, a new access completes normally.
